// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: requester-side controller for the alu.
// It issues tagged operations to the alu and tracks each one through the alu's fixed latency.
// Results return in order through a credit-protected response FIFO.
module alu_issue_ctrl #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned FUNC_W      = 6,
    parameter int unsigned FLAG_W      = 4,
    parameter int unsigned TAG_W       = 4,
    parameter int unsigned ALU_LATENCY = 1,
    parameter int unsigned RSP_DEPTH   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [WIDTH-1:0]  req_a,
    input  logic [WIDTH-1:0]  req_b,
    input  logic [FUNC_W-1:0] req_func,
    input  logic [TAG_W-1:0]  req_tag,
    output logic [WIDTH-1:0]  operand_a,
    output logic [WIDTH-1:0]  operand_b,
    output logic [FUNC_W-1:0] func,
    input  logic [WIDTH-1:0]  result,
    input  logic [FLAG_W-1:0] flags,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [WIDTH-1:0]  rsp_result,
    output logic [FLAG_W-1:0] rsp_flags,
    output logic [TAG_W-1:0]  rsp_tag,
    output logic              busy
);

    localparam int unsigned STAGES = ALU_LATENCY + 1;
    localparam int unsigned PTR_W  = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int unsigned CNT_W  = $clog2(RSP_DEPTH + 1);

    typedef struct packed {
        logic [WIDTH-1:0]  result;
        logic [FLAG_W-1:0] flags;
        logic [TAG_W-1:0]  tag;
    } rsp_t;

    logic              r_live;
    logic [STAGES-1:0] r_vld;
    logic [TAG_W-1:0]  r_tag [STAGES];
    rsp_t              r_mem [RSP_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_fifo_cnt;
    logic [CNT_W-1:0]  r_credits;

    logic              w_accept;
    logic              w_wr;
    logic              w_pop;
    logic              w_fifo_ne;
    rsp_t              w_wdata;
    rsp_t              w_head;

    // Handshake and FIFO control decodes; flush suppresses accept, write and pop
    assign w_fifo_ne = (r_fifo_cnt != '0);
    assign req_ready = r_live & (r_credits < CNT_W'(RSP_DEPTH)) & ~flush;
    assign w_accept  = req_valid & req_ready;
    assign w_wr      = r_vld[STAGES-1] & ~flush;
    assign w_pop     = w_fifo_ne & rsp_ready & ~flush;
    assign w_wdata   = '{result: result, flags: flags, tag: r_tag[STAGES-1]};
    assign w_head    = r_mem[r_rd_ptr];

    // Response head is forced to zero while the FIFO is empty
    assign rsp_valid  = w_fifo_ne;
    assign rsp_result = w_fifo_ne ? w_head.result : '0;
    assign rsp_flags  = w_fifo_ne ? w_head.flags  : '0;
    assign rsp_tag    = w_fifo_ne ? w_head.tag    : '0;
    assign busy       = (|r_vld) | w_fifo_ne;

    // Accepting requests is enabled from the first edge after reset release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_live <= 1'b0;
        end else begin
            r_live <= 1'b1;
        end
    end

    // Operand registers driving the alu; they load on accept and hold otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            operand_a <= '0;
            operand_b <= '0;
            func      <= '0;
        end else if (w_accept) begin
            operand_a <= req_a;
            operand_b <= req_b;
            func      <= req_func;
        end
    end

    // Valid/tag pipeline that mirrors the alu latency; the last stage marks a result to capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld <= '0;
            for (int unsigned i = 0; i < STAGES; i++) begin
                r_tag[i] <= '0;
            end
        end else if (flush) begin
            r_vld <= '0;
        end else begin
            r_vld    <= {r_vld[STAGES-2:0], w_accept};
            r_tag[0] <= req_tag;
            for (int unsigned i = 1; i < STAGES; i++) begin
                r_tag[i] <= r_tag[i-1];
            end
        end
    end

    // FIFO storage; contents are qualified by the count, so no reset is needed
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= w_wdata;
        end
    end

    // FIFO pointers and occupancy count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_fifo_cnt <= '0;
        end else if (flush) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_fifo_cnt <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_wr, w_pop})
                2'b10:   r_fifo_cnt <= r_fifo_cnt + CNT_W'(1);
                2'b01:   r_fifo_cnt <= r_fifo_cnt - CNT_W'(1);
                default: r_fifo_cnt <= r_fifo_cnt;
            endcase
        end
    end

    // Outstanding-operation credits: in-flight plus queued responses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_credits <= '0;
        end else if (flush) begin
            r_credits <= '0;
        end else begin
            case ({w_accept, w_pop})
                2'b10:   r_credits <= r_credits + CNT_W'(1);
                2'b01:   r_credits <= r_credits - CNT_W'(1);
                default: r_credits <= r_credits;
            endcase
        end
    end

    // Credit invariants: the FIFO is never written while full and credits never exceed depth
    always @(posedge clk) begin
        if (rst_n) begin
            assert (!(w_wr && (r_fifo_cnt == CNT_W'(RSP_DEPTH))));
            assert (r_credits <= CNT_W'(RSP_DEPTH));
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Testbench for alu_issue_ctrl: a behavioural alu stub plus an in-order queue reference model.
module tb_alu_issue_ctrl;

    localparam int unsigned W     = 32;
    localparam int unsigned FW    = 6;
    localparam int unsigned GW    = 4;
    localparam int unsigned TW    = 4;
    localparam int unsigned LAT   = 1;
    localparam int unsigned DEPTH = 4;

    localparam logic [FW-1:0] F_ADD = 6'd0;
    localparam logic [FW-1:0] F_SUB = 6'd1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush;
    logic          req_valid;
    logic          req_ready;
    logic [W-1:0]  req_a;
    logic [W-1:0]  req_b;
    logic [FW-1:0] req_func;
    logic [TW-1:0] req_tag;
    logic [W-1:0]  operand_a;
    logic [W-1:0]  operand_b;
    logic [FW-1:0] func;
    logic [W-1:0]  result;
    logic [GW-1:0] flags;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [W-1:0]  rsp_result;
    logic [GW-1:0] rsp_flags;
    logic [TW-1:0] rsp_tag;
    logic          busy;

    typedef struct {
        logic [W-1:0]  res;
        logic [GW-1:0] flg;
        logic [TW-1:0] tag;
        int            rdy;
    } exp_t;

    exp_t         q[$];
    logic [W-1:0] got[$];
    int           cyc;
    int           checks;
    int           failures;
    bit           live;
    bit           last_acc;

    always #5 clk = ~clk;

    alu_issue_ctrl #(
        .WIDTH(W), .FUNC_W(FW), .FLAG_W(GW), .TAG_W(TW),
        .ALU_LATENCY(LAT), .RSP_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_func(req_func), .req_tag(req_tag),
        .operand_a(operand_a), .operand_b(operand_b), .func(func),
        .result(result), .flags(flags),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_flags(rsp_flags), .rsp_tag(rsp_tag),
        .busy(busy)
    );

    // Behavioural alu: {result, flags{N,Z,C,0}}
    function automatic logic [W+GW-1:0] alu_f(input logic [W-1:0] a, input logic [W-1:0] b,
                                              input logic [FW-1:0] f);
        logic [W:0]   s;
        logic [W-1:0] r;
        logic         c;
        s = '0;
        c = 1'b0;
        case (f)
            F_ADD:   begin s = {1'b0, a} + {1'b0, b}; r = s[W-1:0]; c = s[W]; end
            F_SUB:   begin s = {1'b0, a} - {1'b0, b}; r = s[W-1:0]; c = s[W]; end
            6'd2:    r = a & b;
            6'd3:    r = a | b;
            6'd4:    r = a ^ b;
            default: r = a;
        endcase
        return {r, r[W-1], (r == '0), c, 1'b0};
    endfunction

    // Alu stub with a single register stage (one edge of latency)
    always_ff @(posedge clk) begin
        {result, flags} <= alu_f(operand_a, operand_b, func);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input bit v, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [FW-1:0] f, input logic [TW-1:0] t);
        req_valid = v;
        req_a     = a;
        req_b     = b;
        req_func  = f;
        req_tag   = t;
    endtask

    // One clock cycle: check outputs against the model, update the model, advance to the next negedge
    task automatic tick();
        bit                exp_valid;
        bit                acc;
        bit                pop;
        logic [W+GW-1:0]   rf;
        #1;
        exp_valid = (q.size() != 0) && (q[0].rdy <= cyc);
        chk("req_ready", 64'(req_ready), 64'(live && (q.size() < int'(DEPTH)) && !flush));
        chk("busy", 64'(busy), 64'(q.size() != 0));
        chk("rsp_valid", 64'(rsp_valid), 64'(exp_valid));
        if (exp_valid && rsp_valid) begin
            chk("rsp_result", 64'(rsp_result), 64'(q[0].res));
            chk("rsp_flags", 64'(rsp_flags), 64'(q[0].flg));
            chk("rsp_tag", 64'(rsp_tag), 64'(q[0].tag));
        end
        acc = req_valid && req_ready;
        pop = rsp_valid && rsp_ready && !flush;
        if (pop && q.size() != 0) begin
            got.push_back(rsp_result);
            void'(q.pop_front());
        end
        if (acc) begin
            rf = alu_f(req_a, req_b, req_func);
            q.push_back('{res: rf[W+GW-1:GW], flg: rf[GW-1:0], tag: req_tag, rdy: cyc + int'(LAT) + 2});
        end
        if (flush) begin
            q.delete();
        end
        last_acc = acc;
        @(posedge clk);
        if (rst_n) live = 1'b1;
        @(negedge clk);
        cyc++;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_opa"}, 64'(operand_a), 64'd0);
        chk({tag, "_opb"}, 64'(operand_b), 64'd0);
        chk({tag, "_func"}, 64'(func), 64'd0);
        chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
        chk({tag, "_rsp_result"}, 64'(rsp_result), 64'd0);
        chk({tag, "_rsp_flags"}, 64'(rsp_flags), 64'd0);
        chk({tag, "_rsp_tag"}, 64'(rsp_tag), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_req_ready"}, 64'(req_ready), 64'd0);
    endtask

    initial begin
        int k;
        int n_acc;
        checks    = 0;
        failures  = 0;
        cyc       = 0;
        live      = 1'b0;
        rst_n     = 1'b1;
        flush     = 1'b0;
        rsp_ready = 1'b0;
        set_req(1'b0, '0, '0, '0, '0);
        #1 rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        tick();
        tick();

        // 1: single add, response three cycles after accept
        set_req(1'b1, 32'd100, 32'd75, F_ADD, 4'd3);
        tick();
        chk("t1_accept", 64'(last_acc), 64'd1);
        set_req(1'b0, '0, '0, '0, '0);
        tick();
        chk("t1_no_early_rsp", 64'(rsp_valid), 64'd0);
        tick();
        chk("t1_rsp_valid", 64'(rsp_valid), 64'd1);
        chk("t1_result", 64'(rsp_result), 64'd175);
        chk("t1_tag", 64'(rsp_tag), 64'd3);
        rsp_ready = 1'b1;
        tick();
        chk("t1_busy_after_pop", 64'(busy), 64'd0);

        // 2: back-to-back subtracts drain one per cycle in order
        got.delete();
        set_req(1'b1, 32'd7, 32'd7, F_SUB, 4'd1);
        tick();
        set_req(1'b1, 32'd99, 32'd1, F_SUB, 4'd2);
        tick();
        set_req(1'b1, 32'd9999, 32'hFFFF_FC19, F_SUB, 4'd4);
        tick();
        set_req(1'b0, '0, '0, '0, '0);
        repeat (5) tick();
        chk("t2_count", 64'(got.size()), 64'd3);
        if (got.size() == 3) begin
            chk("t2_r0", 64'(got[0]), 64'd0);
            chk("t2_r1", 64'(got[1]), 64'd98);
            chk("t2_r2", 64'(got[2]), 64'd10998);
        end

        // 3: consumer stalled, six requests offered, only four credits
        got.delete();
        rsp_ready = 1'b0;
        k = 0;
        n_acc = 0;
        for (int i = 0; i < 6; i++) begin
            set_req(1'b1, W'(k), 32'd10, F_ADD, TW'(8 + k));
            tick();
            if (last_acc) begin
                k++;
                n_acc++;
            end
        end
        chk("t3_accepted", 64'(n_acc), 64'd4);
        chk("t3_ready_low", 64'(req_ready), 64'd0);
        chk("t3_fifo_full_valid", 64'(rsp_valid), 64'd1);
        rsp_ready = 1'b1;
        for (int i = 0; i < 20 && k < 6; i++) begin
            set_req(1'b1, W'(k), 32'd10, F_ADD, TW'(8 + k));
            tick();
            if (last_acc) k++;
        end
        chk("t3_remaining_accepted", 64'(k), 64'd6);
        set_req(1'b0, '0, '0, '0, '0);
        repeat (8) tick();
        chk("t3_drained", 64'(got.size()), 64'd6);
        for (int i = 0; i < 6 && i < got.size(); i++) begin
            chk("t3_order", 64'(got[i]), 64'(i + 10));
        end

        // 4: full FIFO then continuous pop with continuous requests
        rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_req(1'b1, W'($urandom), W'($urandom), F_ADD, TW'(i));
            tick();
        end
        set_req(1'b0, '0, '0, '0, '0);
        repeat (3) tick();
        chk("t4_full_ready", 64'(req_ready), 64'd0);
        rsp_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            set_req(1'b1, W'($urandom), W'($urandom), F_SUB, TW'($urandom));
            tick();
        end
        set_req(1'b0, '0, '0, '0, '0);
        repeat (8) tick();
        chk("t4_idle", 64'(busy), 64'd0);

        // 5: flush with two in flight and one queued
        rsp_ready = 1'b0;
        set_req(1'b1, 32'd1, 32'd2, F_ADD, 4'd5);
        tick();
        set_req(1'b0, '0, '0, '0, '0);
        tick();
        set_req(1'b1, 32'd3, 32'd4, F_ADD, 4'd6);
        tick();
        set_req(1'b1, 32'd5, 32'd6, F_ADD, 4'd7);
        tick();
        set_req(1'b0, '0, '0, '0, '0);
        chk("t5_queued", 64'(rsp_valid), 64'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("t5_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("t5_busy", 64'(busy), 64'd0);
        got.delete();
        rsp_ready = 1'b1;
        repeat (6) tick();
        chk("t5_no_stale", 64'(got.size()), 64'd0);

        // 6: asynchronous reset mid-stream, then a clean add
        set_req(1'b1, 32'd11, 32'd22, F_ADD, 4'd9);
        tick();
        set_req(1'b1, 32'd33, 32'd44, F_ADD, 4'd10);
        tick();
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        q.delete();
        live = 1'b0;
        set_req(1'b0, '0, '0, '0, '0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        got.delete();
        set_req(1'b1, 32'd1024, 32'd2048, F_ADD, 4'd12);
        tick();
        set_req(1'b0, '0, '0, '0, '0);
        repeat (5) tick();
        chk("t6_count", 64'(got.size()), 64'd1);
        if (got.size() == 1) chk("t6_result", 64'(got[0]), 64'd3072);

        // Randomized traffic with occasional flush
        for (int i = 0; i < 400; i++) begin
            set_req(($urandom_range(0, 3) != 0), W'($urandom), W'($urandom),
                    FW'($urandom_range(0, 5)), TW'($urandom));
            rsp_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 39) == 0);
            tick();
        end
        flush = 1'b0;
        set_req(1'b0, '0, '0, '0, '0);
        rsp_ready = 1'b1;
        repeat (10) tick();
        chk("final_idle", 64'(busy), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
